// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction fetch unit with a circular instruction queue,
// a bimodal branch predictor (2-bit counters) and JALR stall handling.
//
// Ports
//   clk, rst_in         clock, asynchronous active-high reset
//   rdy_in              global ready; low freezes every piece of state
//   roll_back, corr_pc  misprediction flush and restart PC
//   mc_req, mc_aout     fetch request / address to memory controller
//   mc_instr_in_en/_in  returned instruction (accepted only while mc_req)
//   de_out_en, de_ready head-of-queue handshake to the decoder
//   de_pc_out, de_instr_out, de_pred_taken   head entry contents
//   jalr_ready, jalr_val                     rs1 of a stalled JALR
//   br_upd_en, br_upd_pc, br_upd_taken       committed branch outcome
module ifetch_queue #(
  parameter int QDEPTH_LOG = 3,
  parameter int BHT_LOG    = 6
) (
  input  logic        clk,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        roll_back,
  input  logic [31:0] corr_pc,
  output logic        mc_req,
  output logic [31:0] mc_aout,
  input  logic        mc_instr_in_en,
  input  logic [31:0] mc_instr_in,
  output logic        de_out_en,
  input  logic        de_ready,
  output logic [31:0] de_pc_out,
  output logic [31:0] de_instr_out,
  output logic        de_pred_taken,
  input  logic        jalr_ready,
  input  logic [31:0] jalr_val,
  input  logic        br_upd_en,
  input  logic [31:0] br_upd_pc,
  input  logic        br_upd_taken
);

  localparam int QDEPTH = 1 << QDEPTH_LOG;
  localparam int BHT_N  = 1 << BHT_LOG;

  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_BR   = 7'b1100011;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        pred;
  } qent_t;

  qent_t                 q [QDEPTH];
  logic [QDEPTH_LOG-1:0] head, tail;
  logic [QDEPTH_LOG:0]   count;
  logic [31:0]           pc, jalr_imm;
  logic                  stall;
  logic [1:0]            bht [BHT_N];

  logic                  push, pop, pred_nxt;
  logic [31:0]           pc_nxt;
  logic                  stall_nxt;
  logic [6:0]            opc;
  logic [31:0]           i_imm, b_imm, j_imm;
  logic [BHT_LOG-1:0]    lk_idx, up_idx;

  assign opc    = mc_instr_in[6:0];
  assign i_imm  = {{20{mc_instr_in[31]}}, mc_instr_in[31:20]};
  assign b_imm  = {{20{mc_instr_in[31]}}, mc_instr_in[7], mc_instr_in[30:25],
                   mc_instr_in[11:8], 1'b0};
  assign j_imm  = {{12{mc_instr_in[31]}}, mc_instr_in[19:12], mc_instr_in[20],
                   mc_instr_in[30:21], 1'b0};
  assign lk_idx = pc[BHT_LOG+1:2];
  assign up_idx = br_upd_pc[BHT_LOG+1:2];

  logic unused_upd_bits;
  assign unused_upd_bits = ^{br_upd_pc[31:BHT_LOG+2], br_upd_pc[1:0]};

  // count never exceeds QDEPTH, so its MSB alone marks "full".
  assign mc_req    = rdy_in && !roll_back && !stall && !count[QDEPTH_LOG];
  assign mc_aout   = pc;
  assign push      = mc_req && mc_instr_in_en;
  assign de_out_en = (count != '0) && rdy_in;
  assign pop       = de_out_en && de_ready;

  assign de_pc_out     = q[head].pc;
  assign de_instr_out  = q[head].instr;
  assign de_pred_taken = q[head].pred;

  // Next-PC selection; push and jalr resolution are mutually exclusive
  // because mc_req is held low while stalled.
  always_comb begin
    pc_nxt    = pc;
    stall_nxt = stall;
    pred_nxt  = 1'b0;
    if (push) begin
      case (opc)
        OP_JAL: begin
          pred_nxt = 1'b1;
          pc_nxt   = pc + j_imm;
        end
        OP_BR: begin
          pred_nxt = bht[lk_idx][1];
          pc_nxt   = pred_nxt ? pc + b_imm : pc + 32'd4;
        end
        OP_JALR: stall_nxt = 1'b1;
        default: pc_nxt = pc + 32'd4;
      endcase
    end else if (stall && jalr_ready) begin
      pc_nxt    = (jalr_val + jalr_imm) & ~32'h1;
      stall_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      pc       <= '0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      stall    <= 1'b0;
      jalr_imm <= '0;
    end else if (rdy_in) begin
      if (roll_back) begin
        pc    <= corr_pc;
        head  <= '0;
        tail  <= '0;
        count <= '0;
        stall <= 1'b0;
      end else begin
        pc    <= pc_nxt;
        stall <= stall_nxt;
        if (push) tail <= tail + 1'b1;
        if (pop)  head <= head + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: ;
        endcase
        if (push && opc == OP_JALR) jalr_imm <= i_imm;
      end
    end
  end

  // Queue payload needs no reset: head/tail/count gate its visibility.
  always_ff @(posedge clk) begin
    if (push) q[tail] <= '{pc: pc, instr: mc_instr_in, pred: pred_nxt};
  end

  // Counters are registered, so a same-cycle lookup sees the old value.
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < BHT_N; i++) bht[i] <= 2'b01;
    end else if (rdy_in && br_upd_en) begin
      if (br_upd_taken && bht[up_idx] != 2'b11)
        bht[up_idx] <= bht[up_idx] + 2'b01;
      else if (!br_upd_taken && bht[up_idx] != 2'b00)
        bht[up_idx] <= bht[up_idx] - 2'b01;
    end
  end

endmodule
